// File: rtl/qam_pkg.sv
// Shared definitions for the QAM serial path: default symbol width and bit
// period, the parallel-to-serial FSM state type and a frame-length helper.
// The frame length follows the P2S_PARITY_EN macro (one extra parity bit).
package qam_pkg;

  localparam int SYM_W_DEF      = 4;
  localparam int BIT_PERIOD_DEF = 8;

  // IDLE: shift register empty. SHIFT: bits of a symbol remain to be emitted.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_t;

  // Number of flagged bits emitted per symbol.
  function automatic int frame_bits(input int sym_w);
`ifdef P2S_PARITY_EN
    return sym_w + 1;
`else
    return sym_w;
`endif
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period tick generator: counts 0..BIT_PERIOD-1 while start is high and
// holds its count while start is low. tick is high in the cycle where the
// count sits at its last value with start high.
module bit_tick_gen
  import qam_pkg::*;
#(
  parameter int BIT_PERIOD = BIT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic tick
);

  // BIT_PERIOD is limited to 255, so an 8-bit counter always suffices.
  localparam logic [7:0] LAST = 8'(BIT_PERIOD - 1);

  logic [7:0] count_reg;

  // Free-running period counter, frozen while start is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (start) begin
      if (count_reg == LAST) begin
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + 8'd1;
      end
    end
  end

  assign tick = start && (count_reg == LAST);

endmodule

// File: rtl/parallel_2_serial.sv
// Parallel-to-serial converter with a one-symbol hold register in front of
// the shift register. Each bit stays on serial_out for BIT_PERIOD clocks and
// is marked by a one-cycle data_flag strobe; a held symbol is loaded and its
// first bit emitted on the same tick that follows the previous last bit, so
// a continuous stream has no gaps.
// Optional feature: define P2S_PARITY_EN to append an even-parity bit after
// every symbol (computed from the symbol as it is loaded).
module parallel_2_serial
  import qam_pkg::*;
#(
  parameter int BIT_PERIOD = BIT_PERIOD_DEF,
  parameter int SYM_W      = SYM_W_DEF,
  parameter int MSB_FIRST  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SYM_W-1:0] parallel_data,
  input  logic             par_valid,
  output logic             par_ready,
  output logic             serial_out,
  output logic             data_flag,
  output logic             busy
);

  localparam int FRAME_W = frame_bits(SYM_W);
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  p2s_state_t         state_reg, state_next;
  logic [FRAME_W-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               serial_reg, serial_next;
  logic               flag_reg, flag_next;
  logic [SYM_W-1:0]   hold_data_reg, hold_data_next;
  logic               hold_full_reg, hold_full_next;
  logic               ready_reg;

  logic               tick;
  logic               accept;
  logic               shift_empty;
  logic               load;
  logic [FRAME_W-1:0] load_frame;
  logic [FRAME_W-1:0] src_frame;
  logic               head_bit;
  logic [FRAME_W-1:0] rest_bits;

  bit_tick_gen #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .tick (tick)
  );

  assign accept      = par_valid && ready_reg;
  // cnt_reg == 0 in SHIFT means the last bit is out and the next tick may
  // load the held symbol without an idle bit period.
  assign shift_empty = (state_reg == IDLE) || (cnt_reg == '0);
  assign load        = tick && shift_empty && hold_full_reg;
  assign src_frame   = load ? load_frame : shift_reg;

  // Build the frame for the held symbol, parity bit emitted last.
`ifdef P2S_PARITY_EN
  logic parity_bit;
  assign parity_bit = ^hold_data_reg;
  if (MSB_FIRST != 0) begin : g_frame_msb
    assign load_frame = {hold_data_reg, parity_bit};
  end else begin : g_frame_lsb
    assign load_frame = {parity_bit, hold_data_reg};
  end
`else
  assign load_frame = hold_data_reg;
`endif

  // Pick the outgoing bit and the remainder according to bit order.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign head_bit  = src_frame[FRAME_W-1];
    assign rest_bits = {src_frame[FRAME_W-2:0], 1'b0};
  end else begin : g_lsb_first
    assign head_bit  = src_frame[0];
    assign rest_bits = {1'b0, src_frame[FRAME_W-1:1]};
  end

  // Next-state, emission and hold-register update logic.
  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    cnt_next       = cnt_reg;
    serial_next    = serial_reg;
    flag_next      = 1'b0;
    hold_data_next = hold_data_reg;
    hold_full_next = hold_full_reg;

    if (tick) begin
      if (!shift_empty) begin
        serial_next = head_bit;
        shift_next  = rest_bits;
        flag_next   = 1'b1;
        cnt_next    = cnt_reg - CNT_W'(1);
        if ((cnt_reg == CNT_W'(1)) && !hold_full_reg) begin
          state_next = IDLE;
        end
      end else if (hold_full_reg) begin
        serial_next = head_bit;
        shift_next  = rest_bits;
        flag_next   = 1'b1;
        cnt_next    = CNT_W'(FRAME_W - 1);
        state_next  = SHIFT;
      end else begin
        state_next = IDLE;
      end
    end

    // A same-cycle accept always wins over the transfer so nothing is lost.
    if (accept) begin
      hold_data_next = parallel_data;
      hold_full_next = 1'b1;
    end else if (load) begin
      hold_full_next = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      serial_reg    <= 1'b0;
      flag_reg      <= 1'b0;
      hold_data_reg <= '0;
      hold_full_reg <= 1'b0;
      ready_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      cnt_reg       <= cnt_next;
      serial_reg    <= serial_next;
      flag_reg      <= flag_next;
      hold_data_reg <= hold_data_next;
      hold_full_reg <= hold_full_next;
      ready_reg     <= ~hold_full_next;
    end
  end

  assign par_ready  = ready_reg;
  assign serial_out = serial_reg;
  assign data_flag  = flag_reg;
  assign busy       = (state_reg == SHIFT) || hold_full_reg;

endmodule
